// File: rtl/execute_stage_if.sv
// ----------------------------------------------------------------------------
// execute_stage_if
// Bundles the operand/control input side and the result output side of the
// execute stage.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer keeps its valid high and
// its payload stable until that edge. A consumer may change ready at any time.
// Input side : inValid/inReady with aluOp, readData1/2, pcIn,
//              pcOffsetFilled, branchFlag, uncondBranchFlag.
// Output side: outValid/outReady with aluResult, zeroFlag, branchTarget,
//              takeBranch.
//
// Modports:
//   slave  - the execute stage itself.
//   master - the surroundings, which drive operands and consume results.
// ----------------------------------------------------------------------------
interface execute_stage_if #(
  parameter int WIDTH = 32
);
  logic             inValid;
  logic             inReady;
  logic [3:0]       aluOp;
  logic [WIDTH-1:0] readData1;
  logic [WIDTH-1:0] readData2;
  logic [WIDTH-1:0] pcIn;
  logic [WIDTH-1:0] pcOffsetFilled;
  logic             branchFlag;
  logic             uncondBranchFlag;
  logic [WIDTH-1:0] aluResult;
  logic             zeroFlag;
  logic [WIDTH-1:0] branchTarget;
  logic             takeBranch;
  logic             outValid;
  logic             outReady;

  modport slave (
    input  inValid, aluOp, readData1, readData2, pcIn, pcOffsetFilled,
           branchFlag, uncondBranchFlag, outReady,
    output inReady, aluResult, zeroFlag, branchTarget, takeBranch, outValid
  );

  modport master (
    output inValid, aluOp, readData1, readData2, pcIn, pcOffsetFilled,
           branchFlag, uncondBranchFlag, outReady,
    input  inReady, aluResult, zeroFlag, branchTarget, takeBranch, outValid
  );
endinterface

// File: rtl/execute_stage.sv
// ----------------------------------------------------------------------------
// execute_stage
// Execute stage of the multi-cycle LEGv8 datapath. It computes the ALU result,
// the zero flag and the branch decision and target. Single-cycle operations
// finish on the accept edge. MUL runs as an iterative shift-add: 32
// iterations, then one commit edge.
//
// Ports:
//   clock       - all state updates on the rising edge
//   reset       - asynchronous, active-high
//   bus         - execute_stage_if.slave (operand input and result output
//                 handshakes)
//   state_dbg_o - current FSM state (IDLE=0, MUL=1, DONE=2)
// ----------------------------------------------------------------------------
module execute_stage #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clock,
  input  logic            reset,
  execute_stage_if.slave  bus,
  output logic [1:0]      state_dbg_o
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(MUL_CYCLES) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_ORR   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_LSL   = 4'b1000;
  localparam logic [3:0] OP_LSR   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             take_q, take_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  // Branch info for a MUL in flight. It is held here so that the visible
  // outputs change only at the commit edge.
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             pend_br_q, pend_br_d;
  logic             pend_ub_q, pend_ub_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] new_target;
  logic             mul_done;
  logic [WIDTH-1:0] acc_step;

  // DONE accepts a new op only in the cycle its own result is consumed.
  assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.outReady);
  assign accept     = bus.inValid && in_ready;
  assign new_target = bus.pcIn + {bus.pcOffsetFilled[WIDTH-3:0], 2'b00};
  // The counter reaches MUL_CYCLES after the last iteration. The following
  // edge commits the accumulator, so the latency is fixed.
  assign mul_done   = (count_q == CW'(MUL_CYCLES));
  assign acc_step   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    alu_res = '0;
    case (bus.aluOp)
      OP_AND:   alu_res = bus.readData1 & bus.readData2;
      OP_ORR:   alu_res = bus.readData1 | bus.readData2;
      OP_ADD:   alu_res = bus.readData1 + bus.readData2;
      OP_SUB:   alu_res = bus.readData1 - bus.readData2;
      OP_PASSB: alu_res = bus.readData2;
      OP_NOR:   alu_res = ~(bus.readData1 | bus.readData2);
      OP_LSL:   alu_res = bus.readData1 << bus.readData2[SHW-1:0];
      OP_LSR:   alu_res = bus.readData1 >> bus.readData2[SHW-1:0];
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
    zero_d        = zero_q;
    target_d      = target_q;
    take_d        = take_q;
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    count_d       = count_q;
    pend_target_d = pend_target_q;
    pend_br_d     = pend_br_q;
    pend_ub_d     = pend_ub_q;

    if (accept) begin
      if (bus.aluOp == OP_MUL) begin
        state_d       = ST_MUL;
        acc_d         = '0;
        mcand_d       = bus.readData1;
        mplier_d      = bus.readData2;
        count_d       = '0;
        pend_target_d = new_target;
        pend_br_d     = bus.branchFlag;
        pend_ub_d     = bus.uncondBranchFlag;
      end else begin
        state_d  = ST_DONE;
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        target_d = new_target;
        take_d   = bus.uncondBranchFlag || (bus.branchFlag && (alu_res == '0));
      end
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_MUL: begin
          if (mul_done) begin
            state_d  = ST_DONE;
            result_d = acc_q;
            zero_d   = (acc_q == '0);
            target_d = pend_target_q;
            take_d   = pend_ub_q || (pend_br_q && (acc_q == '0));
          end else begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
          end
        end
        ST_DONE: if (bus.outReady) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      result_q      <= '0;
      zero_q        <= 1'b0;
      target_q      <= '0;
      take_q        <= 1'b0;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      count_q       <= '0;
      pend_target_q <= '0;
      pend_br_q     <= 1'b0;
      pend_ub_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      result_q      <= result_d;
      zero_q        <= zero_d;
      target_q      <= target_d;
      take_q        <= take_d;
      acc_q         <= acc_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      count_q       <= count_d;
      pend_target_q <= pend_target_d;
      pend_br_q     <= pend_br_d;
      pend_ub_q     <= pend_ub_d;
    end
  end

  assign bus.inReady      = in_ready;
  assign bus.outValid     = (state_q == ST_DONE);
  assign bus.aluResult    = result_q;
  assign bus.zeroFlag     = zero_q;
  assign bus.branchTarget = target_q;
  assign bus.takeBranch   = take_q;
  assign state_dbg_o      = state_q;
endmodule
